// File: rtl/gray_converter_arbiter_if.sv
// Request/converter/response bundle for gray_converter_arbiter.
// slave = arbiter side, master = requesters, shared converter and response consumer.
interface gray_converter_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ-1:0]            req_rdy;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat;
  logic                          conv_en;
  logic [DATA_WIDTH-1:0]         conv_gray_dat;
  logic [DATA_WIDTH-1:0]         conv_bin_dat;
  logic                          resp_vld;
  logic                          resp_rdy;
  logic [DATA_WIDTH-1:0]         resp_dat;
  logic [2:0]                    resp_id;
  logic                          busy;

  modport slave (
    input  req_vld, req_dat, conv_bin_dat, resp_rdy,
    output req_rdy, conv_en, conv_gray_dat, resp_vld, resp_dat, resp_id, busy
  );

  modport master (
    output req_vld, req_dat, conv_bin_dat, resp_rdy,
    input  req_rdy, conv_en, conv_gray_dat, resp_vld, resp_dat, resp_id, busy
  );
endinterface

// File: rtl/gray_converter_arbiter.sv
// Arbitrates NUM_REQ Gray-word requesters onto one shared Gray-to-binary converter (GRAY_ARB_FIXED_PRIORITY_EN: lowest index wins, else round-robin).
// Latency: accept edge -> resp_vld two cycles later; at most one conversion per 3 cycles.
// Backpressure: response held stable in RESPOND until resp_rdy; no request is granted meanwhile.
module gray_converter_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gray_converter_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = NUM_REQ'(1);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] gray_q;
  logic [DATA_WIDTH-1:0] bin_q;
  logic [2:0]            id_q;
  logic [2:0]            grant_idx;
  logic                  found;
  logic [DATA_WIDTH-1:0] grant_dat;
`ifndef GRAY_ARB_FIXED_PRIORITY_EN
  logic [2:0]            ptr;
`endif

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
`ifdef GRAY_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_vld[i]) begin
        found     = 1'b1;
        grant_idx = 3'(i);
      end
    end
`else
    // Walk k steps from ptr (wrapping); constant bit indices keep the select static.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req_vld[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
          found     = 1'b1;
          grant_idx = 3'(i);
        end
      end
    end
`endif
  end

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) grant_dat = bus.req_dat[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Reset gates the grant so req_rdy is low while rst_n is held, not only after an edge.
  assign bus.req_rdy       = (rst_n && state == IDLE && found) ? (ONE_HOT_LSB << grant_idx) : '0;
  assign bus.conv_en       = (state == CONVERT);
  assign bus.conv_gray_dat = (state == CONVERT) ? gray_q : '0;
  assign bus.resp_vld      = (state == RESPOND);
  assign bus.resp_dat      = bin_q;
  assign bus.resp_id       = id_q;
  assign bus.busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gray_q <= '0;
      bin_q  <= '0;
      id_q   <= '0;
`ifndef GRAY_ARB_FIXED_PRIORITY_EN
      ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gray_q <= grant_dat;
            id_q   <= grant_idx;
`ifndef GRAY_ARB_FIXED_PRIORITY_EN
            ptr    <= 3'((int'(grant_idx) + 1) % NUM_REQ);
`endif
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          bin_q <= bus.conv_bin_dat;
          state <= RESPOND;
        end
        RESPOND: begin
          if (bus.resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_converter_arbiter.sv
// Directed + randomized bench for gray_converter_arbiter with an arbitration/conversion reference model.
module tb_gray_converter_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   mptr   = 0;

  gray_converter_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

  gray_converter_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared converter: prefix-XOR from the MSB; drives a junk pattern in place of high-Z when disabled.
  always_comb begin
    logic [7:0] b;
    b = '0;
    b[7] = bus.conv_gray_dat[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ bus.conv_gray_dat[i];
    bus.conv_bin_dat = bus.conv_en ? b : 8'hA5;
  end

  function automatic logic [7:0] ref_bin(input logic [7:0] g);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  function automatic int model_grant(input logic [3:0] vld);
    logic [7:0] rot;
    int first;
    first = -1;
`ifdef GRAY_ARB_FIXED_PRIORITY_EN
    rot = {4'b0, vld};
    for (int j = 3; j >= 0; j--) if (rot[j]) first = j;
    return first;
`else
    rot = {vld, vld} >> mptr;
    for (int j = 3; j >= 0; j--) if (rot[j]) first = j;
    return (first < 0) ? -1 : (mptr + first) % 4;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},   32'(bus.req_rdy), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_rvld"},  32'(bus.resp_vld), 0);
    chk({tag, "_rdat"},  32'(bus.resp_dat), 0);
    chk({tag, "_rid"},   32'(bus.resp_id), 0);
    chk({tag, "_cen"},   32'(bus.conv_en), 0);
    chk({tag, "_cgray"}, 32'(bus.conv_gray_dat), 0);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge back in IDLE.
  task automatic txn(input logic [3:0] vld, input logic [31:0] dat, input int stall);
    int id;
    logic [7:0] g;
    logic [7:0] b;
    bus.req_vld  = vld;
    bus.req_dat  = dat;
    bus.resp_rdy = 1'b1;
    #1;
    id = model_grant(vld);
    if (id < 0) begin
      chk("idle_rdy", 32'(bus.req_rdy), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      @(posedge clk);
      @(negedge clk);
      return;
    end
    g = dat[id*8 +: 8];
    b = ref_bin(g);
    chk("grant", 32'(bus.req_rdy), 32'(1) << id);
    chk("busy_idle", 32'(bus.busy), 0);
    chk("cen_idle", 32'(bus.conv_en), 0);
    @(posedge clk);
    mptr = (id + 1) % 4;
    @(negedge clk);
    bus.req_vld = 4'($urandom);
    bus.req_dat = $urandom;
    #1;
    chk("conv_en", 32'(bus.conv_en), 1);
    chk("conv_gray", 32'(bus.conv_gray_dat), 32'(g));
    chk("rdy_conv", 32'(bus.req_rdy), 0);
    chk("rvld_conv", 32'(bus.resp_vld), 0);
    chk("busy_conv", 32'(bus.busy), 1);
    @(posedge clk);
    @(negedge clk);
    bus.resp_rdy = (stall == 0);
    bus.req_vld  = 4'hF;
    #1;
    chk("resp_vld", 32'(bus.resp_vld), 1);
    chk("resp_dat", 32'(bus.resp_dat), 32'(b));
    chk("resp_id", 32'(bus.resp_id), 32'(id));
    chk("cen_resp", 32'(bus.conv_en), 0);
    chk("cgray_resp", 32'(bus.conv_gray_dat), 0);
    chk("rdy_resp", 32'(bus.req_rdy), 0);
    for (int s = 1; s <= stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      if (s == stall) bus.resp_rdy = 1'b1;
      bus.req_dat = $urandom;
      #1;
      chk("hold_vld", 32'(bus.resp_vld), 1);
      chk("hold_dat", 32'(bus.resp_dat), 32'(b));
      chk("hold_id", 32'(bus.resp_id), 32'(id));
      chk("hold_rdy", 32'(bus.req_rdy), 0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req_vld  = 4'hF;
    bus.req_dat  = $urandom;
    bus.resp_rdy = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;

    // All four valid with resp_rdy high: one response every 3 cycles.
    for (int n = 0; n < 5; n++) txn(4'hF, $urandom, 0);

    txn(4'b0000, $urandom, 0);
    txn(4'b0100, 32'h00C0_0000, 0);
    txn(4'b1010, $urandom, 0);
    txn(4'b1010, $urandom, 0);
    txn(4'b0001, $urandom, 5);

    for (int n = 0; n < 40; n++) txn(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));

    // Reset in the middle of a conversion.
    bus.req_vld  = 4'b0110;
    bus.req_dat  = $urandom;
    bus.resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_cen", 32'(bus.conv_en), 1);
    bus.req_vld = 4'hF;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    txn(4'b1010, $urandom, 0);

    for (int g = 0; g < 256; g++) txn(4'b0001, {24'($urandom), 8'(g)}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_converter_arbiter.md
GRAY_CONVERTER_ARBITER -- requirements
Module: gray_converter_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of every Gray/binary data bus.
REQ-002 Parameter: NUM_REQ, 4, number of requester channels (2..8).
REQ-003 Clock_In  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_N_In  input  1  reset, asynchronous assert, active-low.
REQ-005 Req_Valid_In  input  NUM_REQ  per-channel request valid.
REQ-006 Req_Gray_Data_In  input  NUM_REQ*DATA_WIDTH  per-channel Gray word; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Req_Ready_Out  output  NUM_REQ  per-channel accept, one-hot or zero.
REQ-008 Conv_Enable_Out  output  1  enable to the shared Gray-to-binary converter.
REQ-009 Conv_Gray_Data_Out  output  DATA_WIDTH  Gray word to the shared converter.
REQ-010 Conv_Binary_Data_In  input  DATA_WIDTH  binary result from the shared converter (high-Z when its enable is low).
REQ-011 Resp_Valid_Out  output  1  response valid.
REQ-012 Resp_Ready_In  input  1  response consumer ready.
REQ-013 Resp_Binary_Data_Out  output  DATA_WIDTH  registered binary result.
REQ-014 Resp_Id_Out  output  3  index of the channel that owns the response.
REQ-015 Busy_Out  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CONVERT, RESPOND; encoding free, unreachable codes SHALL return to IDLE next cycle.
REQ-017 In IDLE, Req_Ready_Out SHALL be the combinational one-hot grant of the arbiter over Req_Valid_In; zero in CONVERT and RESPOND.
REQ-018 A channel transfer SHALL occur on a rising edge with Req_Valid_In[i] and Req_Ready_Out[i] both high: capture Gray word and index i, go to CONVERT.
REQ-019 IDLE with no valid request SHALL stay in IDLE.
REQ-020 In CONVERT (exactly one cycle), Conv_Enable_Out SHALL be 1 and Conv_Gray_Data_Out the captured word; at cycle end Conv_Binary_Data_In SHALL be registered into Resp_Binary_Data_Out, state goes to RESPOND.
REQ-021 Outside CONVERT, Conv_Enable_Out SHALL be 0 and Conv_Gray_Data_Out all zeros; Conv_Binary_Data_In SHALL be ignored.
REQ-022 In RESPOND, Resp_Valid_Out SHALL be 1; Resp_Binary_Data_Out and Resp_Id_Out SHALL hold stable until Resp_Ready_In is sampled high, then state goes to IDLE.
REQ-023 Latency from accept edge to Resp_Valid_Out high SHALL be 2 cycles; maximum throughput one conversion per 3 cycles.
REQ-024 Round-robin: search starts at pointer PTR, wraps NUM_REQ-1 to 0; on each accept PTR SHALL become (granted index + 1) mod NUM_REQ.
REQ-025 Req_Valid_In changes during CONVERT/RESPOND SHALL have no effect on the in-flight response.
REQ-026 Resp_Ready_In high outside RESPOND SHALL be ignored.

Reset
REQ-027 Reset_N_In low SHALL immediately force IDLE, PTR=0, Resp_Valid_Out=0, Resp_Binary_Data_Out=0, Resp_Id_Out=0, Conv_Enable_Out=0, Busy_Out=0, Req_Ready_Out=0, including mid-conversion; in-flight data is discarded.
REQ-028 Reset release SHALL be honoured on the first rising edge after Reset_N_In goes high.

Configuration
REQ-029 Macro GRAY_ARB_FIXED_PRIORITY_EN defined: grant SHALL go to the lowest-index valid channel and PTR is unused; undefined: round-robin per REQ-024.

Verification
REQ-030 Single request: ch2 valid, Gray 8'hC0 -> ready ch2 in IDLE, Conv_Enable_Out 1 for one cycle, Resp 8'h80, Id 2, two cycles after accept.
REQ-031 All four valid continuously, Resp_Ready_In tied 1, round-robin -> Resp_Id sequence 0,1,2,3,0; one response per 3 cycles.
REQ-032 Backpressure: Resp_Ready_In low 5 cycles in RESPOND -> Resp_Valid_Out, data, Id stable; no new Req_Ready_Out until release.
REQ-033 Reset asserted during CONVERT -> all outputs reset immediately; next request after release served with Id from PTR=0 search.
REQ-034 GRAY_ARB_FIXED_PRIORITY_EN defined, ch1 and ch3 always valid -> Resp_Id always 1.
REQ-035 Exhaustive data: Gray 8'h00..8'hFF through ch0 against reference converter -> Resp_Binary_Data_Out matches each Gray-to-binary value.
